// File: rtl/stack_unit_if.sv
// Command/data bundle between the Datapath/Controller and the operand stack.
interface stack_unit_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;

  logic             push;
  logic             pop;
  logic             tos;
  logic             clr;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_out;
  logic             d_valid;
  logic             empty;
  logic             full;
  logic [PTR_W-1:0] count;
  logic             ovf;
  logic             unf;
  logic             cmd_err;

  modport master (
    output push, pop, tos, clr, d_in,
    input  d_out, d_valid, empty, full, count, ovf, unf, cmd_err
  );

  modport slave (
    input  push, pop, tos, clr, d_in,
    output d_out, d_valid, empty, full, count, ovf, unf, cmd_err
  );
endinterface

// File: rtl/stack_unit.sv
// Operand stack: register-array storage, pointer management, registered
// top-of-stack read and sticky overflow/underflow/command-conflict flags.
module stack_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  stack_unit_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W = PTR_W - 1;
  localparam logic [PTR_W-1:0] SP_FULL = PTR_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [WIDTH-1:0] d_out_q, d_out_d;
  logic             d_valid_q, d_valid_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             cmd_err_q, cmd_err_d;
  logic             wr_en_c;
  logic             multi_c;
  logic             empty_c;
  logic             full_c;
  logic [IDX_W-1:0] wr_idx_c;
  logic [IDX_W-1:0] rd_idx_c;

  assign empty_c  = (sp_q == '0);
  assign full_c   = (sp_q == SP_FULL);
  assign multi_c  = (bus.push & bus.pop) | (bus.push & bus.tos) | (bus.pop & bus.tos);
  assign wr_idx_c = sp_q[IDX_W-1:0];
  assign rd_idx_c = IDX_W'(sp_q - PTR_W'(1));

  // Prioritised command decode: clr, conflict, then push/pop/tos.
  always_comb begin
    sp_d      = sp_q;
    d_out_d   = d_out_q;
    d_valid_d = 1'b0;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    cmd_err_d = cmd_err_q;
    wr_en_c   = 1'b0;
    if (bus.clr) begin
      sp_d      = '0;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
      cmd_err_d = 1'b0;
    end else if (multi_c) begin
      cmd_err_d = 1'b1;
    end else if (bus.push) begin
      if (full_c) begin
        ovf_d = 1'b1;
      end else begin
        wr_en_c = 1'b1;
        sp_d    = sp_q + PTR_W'(1);
      end
    end else if (bus.pop) begin
      if (empty_c) begin
        unf_d = 1'b1;
      end else begin
        d_out_d   = mem_q[rd_idx_c];
        sp_d      = sp_q - PTR_W'(1);
        d_valid_d = 1'b1;
      end
    end else if (bus.tos) begin
      if (empty_c) begin
        unf_d = 1'b1;
      end else begin
        d_out_d   = mem_q[rd_idx_c];
        d_valid_d = 1'b1;
      end
    end
  end

  // Control and status registers; async reset aborts any command in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q      <= '0;
      d_out_q   <= '0;
      d_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      sp_q      <= sp_d;
      d_out_q   <= d_out_d;
      d_valid_q <= d_valid_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  // Storage array; contents deliberately not reset, write gated off during reset.
  always_ff @(posedge clk) begin
    if (wr_en_c && rst) begin
      mem_q[wr_idx_c] <= bus.d_in;
    end
  end

  assign bus.d_out   = d_out_q;
  assign bus.d_valid = d_valid_q;
  assign bus.empty   = empty_c;
  assign bus.full    = full_c;
  assign bus.count   = sp_q;
  assign bus.ovf     = ovf_q;
  assign bus.unf     = unf_q;
  assign bus.cmd_err = cmd_err_q;
endmodule
